// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with tagged targets and activity statistics.
// Lookup is combinational (0 cycles); training from EX lands at the next rising edge.
// No backpressure: one resolved branch accepted per cycle, lookups never stall.

package bpredictor_pkg;
  localparam int INST_MEMORY_ADDRESS_WIDTH = 8;

  // Gray-like 2-bit counter: bit 1 clear means "predict taken".
  typedef enum logic [1:0] {
    ST  = 2'b00,
    WT  = 2'b01,
    WNT = 2'b11,
    SNT = 2'b10
  } bpredictor_state_t;
endpackage

module branch_predictor_bht #(
  parameter int ADDR_WIDTH  = bpredictor_pkg::INST_MEMORY_ADDRESS_WIDTH,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pred_target,
  output logic                  ex_mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);
  import bpredictor_pkg::*;

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic              r_valid  [ENTRIES];
  logic [TAG_WIDTH-1:0]  r_tag    [ENTRIES];
  bpredictor_state_t r_state  [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
  logic [STAT_WIDTH-1:0] r_stat_branches;
  logic [STAT_WIDTH-1:0] r_stat_mispredicts;

  logic [INDEX_WIDTH-1:0] w_if_idx;
  logic [TAG_WIDTH-1:0]   w_if_tag;
  logic                   w_if_hit;
  logic [INDEX_WIDTH-1:0] w_ex_idx;
  logic [TAG_WIDTH-1:0]   w_ex_tag;
  logic                   w_ex_hit;
  bpredictor_state_t      w_ex_state;
  bpredictor_state_t      w_next_state;

  assign w_if_idx = if_pc[INDEX_WIDTH+1:2];
  assign w_if_tag = if_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_ex_idx = ex_pc[INDEX_WIDTH+1:2];
  assign w_ex_tag = ex_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // Fetch-side lookup reads the registered table directly, so a same-cycle update is not bypassed.
  assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_hit    = w_if_hit;
  assign pred_taken  = w_if_hit && !r_state[w_if_idx][1];
  assign pred_target = w_if_hit ? r_target[w_if_idx] : '0;

  assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_state = r_state[w_ex_idx];

  // A not-taken prediction carries no meaningful target, so the target only matters when taken.
  assign ex_mispredict = ex_valid &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;

  // Saturating step of the direction counter toward the resolved outcome.
  always_comb begin
    w_next_state = w_ex_state;
    if (ex_taken) begin
      case (w_ex_state)
        SNT:     w_next_state = WNT;
        WNT:     w_next_state = WT;
        default: w_next_state = ST;
      endcase
    end else begin
      case (w_ex_state)
        ST:      w_next_state = WT;
        WT:      w_next_state = WNT;
        default: w_next_state = SNT;
      endcase
    end
  end

  // Table training: hits step the counter, taken misses allocate over whatever aliased there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_state[i]  <= WNT;
        r_target[i] <= '0;
      end
    end else if (ex_valid) begin
      if (w_ex_hit) begin
        r_state[w_ex_idx] <= w_next_state;
        if (ex_taken) begin
          r_target[w_ex_idx] <= ex_target;
        end
      end else if (ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_state[w_ex_idx]  <= WT;
        r_target[w_ex_idx] <= ex_target;
      end
    end
  end

  // Activity counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (ex_valid) begin
      if (r_stat_branches != '1) begin
        r_stat_branches <= r_stat_branches + STAT_WIDTH'(1);
      end
      if (ex_mispredict && (r_stat_mispredicts != '1)) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed checks of branch_predictor_bht: lookup, training, aliasing, stats.
// Two instances share stimulus; the second uses 4-bit statistics to reach saturation.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.

module tb_branch_predictor_bht;
  logic       clk;
  logic       rst_n;
  logic [7:0] if_pc;
  logic       ex_valid;
  logic [7:0] ex_pc;
  logic       ex_taken;
  logic [7:0] ex_target;
  logic       ex_pred_taken;
  logic [7:0] ex_pred_target;

  logic        pred_hit, pred_taken, ex_mispredict;
  logic [7:0]  pred_target;
  logic [15:0] stat_branches, stat_mispredicts;

  logic        b_pred_hit, b_pred_taken, b_ex_mispredict;
  logic [7:0]  b_pred_target;
  logic [3:0]  b_stat_branches, b_stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor_bht dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_mispredict(ex_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor_bht #(.STAT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(b_pred_hit), .pred_taken(b_pred_taken), .pred_target(b_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_mispredict(b_ex_mispredict),
    .stat_branches(b_stat_branches), .stat_mispredicts(b_stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Look up a PC and check hit/taken/target on the default instance.
  task automatic look(input string tag, input logic [7:0] pc, input logic hit,
                      input logic tkn, input logic [7:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, ".hit"}, 32'(pred_hit), 32'(hit));
    chk({tag, ".taken"}, 32'(pred_taken), 32'(tkn));
    chk({tag, ".target"}, 32'(pred_target), 32'(tgt));
  endtask

  task automatic stats(input string tag, input int br, input int mp, input int br4, input int mp4);
    chk({tag, ".branches"}, 32'(stat_branches), br);
    chk({tag, ".mispredicts"}, 32'(stat_mispredicts), mp);
    chk({tag, ".branches4"}, 32'(b_stat_branches), br4);
    chk({tag, ".mispredicts4"}, 32'(b_stat_mispredicts), mp4);
  endtask

  task automatic ex(input logic [7:0] pc, input logic tkn, input logic [7:0] tgt,
                    input logic ptkn, input logic [7:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tkn; ex_target = tgt;
    ex_pred_taken = ptkn; ex_pred_target = ptgt;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 8'h40; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

    // Reset state
    #2;
    look("reset", 8'h40, 1'b0, 1'b0, 8'h00);
    chk("reset.mispredict", 32'(ex_mispredict), 0);
    stats("reset", 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    look("post_reset", 8'h14, 1'b0, 1'b0, 8'h00);

    // Allocate 0x14 on a taken miss
    ex(8'h14, 1'b1, 8'h80, 1'b0, 8'h00);
    #1;
    chk("alloc.mispredict", 32'(ex_mispredict), 1);
    tick();
    ex_valid = 1'b0;
    look("alloc", 8'h14, 1'b1, 1'b1, 8'h80);
    stats("alloc", 1, 1, 1, 1);

    // Not-taken training: WT -> WNT -> SNT -> SNT, target kept
    ex(8'h14, 1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    chk("nt.mispredict", 32'(ex_mispredict), 0);
    tick();
    look("nt1_wnt", 8'h14, 1'b1, 1'b0, 8'h80);
    tick();
    look("nt2_snt", 8'h14, 1'b1, 1'b0, 8'h80);
    tick();
    ex_valid = 1'b0;
    look("nt3_snt", 8'h14, 1'b1, 1'b0, 8'h80);
    stats("nt", 4, 1, 4, 1);

    // Taken training: SNT -> WNT -> WT, target rewritten each time
    ex(8'h14, 1'b1, 8'h84, 1'b1, 8'h84);
    #1;
    chk("t1.mispredict", 32'(ex_mispredict), 0);
    tick();
    look("t1_wnt", 8'h14, 1'b1, 1'b0, 8'h84);
    ex(8'h14, 1'b1, 8'h88, 1'b1, 8'h84);
    #1;
    chk("t2.target_mispredict", 32'(ex_mispredict), 1);
    tick();
    ex_valid = 1'b0;
    look("t2_wt", 8'h14, 1'b1, 1'b1, 8'h88);
    stats("t", 6, 2, 6, 2);

    // Alias at 0x54 (index 5, tag 1) evicts 0x14
    ex(8'h54, 1'b1, 8'h20, 1'b0, 8'h00);
    tick();
    ex_valid = 1'b0;
    look("evicted_14", 8'h14, 1'b0, 1'b0, 8'h00);
    look("alias_54", 8'h54, 1'b1, 1'b1, 8'h20);
    stats("alias", 7, 3, 7, 3);

    // Not-taken miss at 0x94 leaves the table alone
    ex(8'h94, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    ex_valid = 1'b0;
    look("ntmiss_94", 8'h94, 1'b0, 1'b0, 8'h00);
    look("ntmiss_54", 8'h54, 1'b1, 1'b1, 8'h20);

    // Allocated state was WT: one not-taken step predicts not taken
    ex(8'h54, 1'b0, 8'h00, 1'b1, 8'h20);
    tick();
    ex_valid = 1'b0;
    look("wt_check_54", 8'h54, 1'b1, 1'b0, 8'h20);
    stats("wt_check", 9, 4, 9, 4);

    // Same-cycle read and update: old contents now, new contents next cycle
    ex(8'h14, 1'b1, 8'h3C, 1'b0, 8'h00);
    look("same1_old", 8'h14, 1'b0, 1'b0, 8'h00);
    tick();
    ex_valid = 1'b0;
    look("same1_new", 8'h14, 1'b1, 1'b1, 8'h3C);
    ex(8'h14, 1'b1, 8'h40, 1'b1, 8'h3C);
    look("same2_old", 8'h14, 1'b1, 1'b1, 8'h3C);
    chk("same2.mispredict", 32'(ex_mispredict), 1);
    tick();
    ex_valid = 1'b0;
    look("same2_new", 8'h14, 1'b1, 1'b1, 8'h40);
    stats("same", 11, 6, 11, 6);

    // 20 mispredicting updates: 4-bit stats hold at 15
    ex(8'h20, 1'b1, 8'h10, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) tick();
    stats("saturate", 31, 26, 15, 15);
    chk("saturate.mispredict4", 32'(b_ex_mispredict), 1);
    look("sat_20", 8'h20, 1'b1, 1'b1, 8'h10);

    // Mid-stream reset with an update still presented: table and stats clear
    rst_n = 1'b0;
    look("midrst_20", 8'h20, 1'b0, 1'b0, 8'h00);
    stats("midrst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    ex_valid = 1'b0;
    look("after_rst_20", 8'h20, 1'b0, 1'b0, 8'h00);
    look("after_rst_14", 8'h14, 1'b0, 1'b0, 8'h00);
    look("after_rst_54", 8'h54, 1'b0, 1'b0, 8'h00);
    chk("after_rst.mispredict", 32'(ex_mispredict), 0);
    stats("after_rst", 0, 0, 0, 0);
    tick();
    stats("after_rst2", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
